// File: rtl/rom_port_arbiter.sv
// Arbitrates the single instruction-ROM read port between instruction fetch (IF)
// and load (LS) requesters; LS wins contention, with a starvation guard for IF.
module rom_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_rvalid,
   input  logic              ls_req,
   input  logic [ADDR_W-1:0] ls_addr,
   output logic              ls_gnt,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_rvalid,
   output logic              stallreq_if,
   output logic              stallreq_ls,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_inst
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   // Counts consecutive contended LS wins; reaching the limit lets IF through.
   logic [3:0] starve_cnt;

   // Grant decision: LS has priority unless IF has been starved long enough.
   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (!rst) begin
         if (if_req && ls_req) begin
            if (starve_cnt == STARVE_LIM)
               if_gnt = 1'b1;
            else
               ls_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end else if (ls_req) begin
            ls_gnt = 1'b1;
         end
      end
   end

   assign rom_ce      = if_gnt | ls_gnt;
   assign rom_addr    = if_gnt ? if_addr : (ls_gnt ? ls_addr : '0);
   assign stallreq_if = if_req & ~if_gnt;
   assign stallreq_ls = ls_req & ~ls_gnt;

   // Capture the ROM word for whichever side owned the port this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_rdata   <= '0;
         ls_rdata   <= '0;
         if_rvalid  <= 1'b0;
         ls_rvalid  <= 1'b0;
         starve_cnt <= '0;
      end else begin
         if_rvalid <= if_gnt;
         ls_rvalid <= ls_gnt;
         if (if_gnt)
            if_rdata <= rom_inst;
         if (ls_gnt)
            ls_rdata <= rom_inst;
         // An IF grant or an idle IF side wipes out any accumulated starvation.
         if (if_gnt || !if_req)
            starve_cnt <= '0;
         else if (ls_gnt && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed vector table, hand-written
// corner sequences and constrained-random traffic against a behavioural model.
module tb_rom_port_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_gnt;
   logic [DATA_W-1:0] if_rdata;
   logic              if_rvalid;
   logic              ls_req = 1'b0;
   logic [ADDR_W-1:0] ls_addr = '0;
   logic              ls_gnt;
   logic [DATA_W-1:0] ls_rdata;
   logic              ls_rvalid;
   logic              stallreq_if;
   logic              stallreq_ls;
   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_inst;

   int n_compared   = 0;
   int n_mismatched = 0;

   rom_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rdata(if_rdata), .if_rvalid(if_rvalid),
      .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
      .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid),
      .stallreq_if(stallreq_if), .stallreq_ls(stallreq_ls),
      .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
   );

   always #5 clk = ~clk;

   // Word-indexed ROM contents; distinct per index so misrouted data shows up.
   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      return 32'hC0DE_0000 ^ ({2'b00, a[ADDR_W-1:2]} * 32'h0001_0003);
   endfunction

   assign rom_inst = rom_ce ? rom_word(rom_addr) : '0;

   always @(negedge clk)
      assert (!(if_gnt && ls_gnt)) else $error("[TB] both grants high together");

   // Behavioural model: registered view plus the count of LS wins IF has sat through.
   logic              m_valid = 1'b0;
   int                m_wins  = 0;
   logic              m_if_rvalid, m_ls_rvalid;
   logic [DATA_W-1:0] m_if_rdata, m_ls_rdata;
   logic              e_if, e_ls;

   typedef struct {
      logic              rst;
      logic              if_req;
      logic [ADDR_W-1:0] if_addr;
      logic              ls_req;
      logic [ADDR_W-1:0] ls_addr;
      logic              exp_if_gnt;
      logic              exp_ls_gnt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic ir, input logic [ADDR_W-1:0] ia,
                                input logic lr, input logic [ADDR_W-1:0] la);
      @(posedge clk);
      #1;
      rst     = r;
      if_req  = ir;
      if_addr = ia;
      ls_req  = lr;
      ls_addr = la;
   endtask

   // Compare every output against the model mid-cycle, then advance the model.
   task automatic checkOutput();
      @(negedge clk);
      e_if = !rst && if_req && (!ls_req || m_wins == STARVE_MAX);
      e_ls = !rst && ls_req && !e_if;
      check("if_gnt", 32'(if_gnt), 32'(e_if));
      check("ls_gnt", 32'(ls_gnt), 32'(e_ls));
      check("rom_ce", 32'(rom_ce), 32'(e_if | e_ls));
      check("rom_addr", rom_addr, e_if ? if_addr : (e_ls ? ls_addr : 32'h0));
      check("stallreq_if", 32'(stallreq_if), 32'(if_req && !e_if));
      check("stallreq_ls", 32'(stallreq_ls), 32'(ls_req && !e_ls));
      if (m_valid) begin
         check("if_rvalid", 32'(if_rvalid), 32'(m_if_rvalid));
         check("ls_rvalid", 32'(ls_rvalid), 32'(m_ls_rvalid));
         check("if_rdata", if_rdata, m_if_rdata);
         check("ls_rdata", ls_rdata, m_ls_rdata);
      end
      if (rst) begin
         m_valid     = 1'b1;
         m_wins      = 0;
         m_if_rvalid = 1'b0;
         m_ls_rvalid = 1'b0;
         m_if_rdata  = '0;
         m_ls_rdata  = '0;
      end else if (m_valid) begin
         m_if_rvalid = e_if;
         m_ls_rvalid = e_ls;
         if (e_if) m_if_rdata = rom_word(if_addr);
         if (e_ls) m_ls_rdata = rom_word(ls_addr);
         if (e_if || !if_req)
            m_wins = 0;
         else if (e_ls)
            m_wins = (m_wins + 1 > STARVE_MAX) ? STARVE_MAX : m_wins + 1;
      end
   endtask

   task automatic addVec(input logic r, input logic ir, input logic lr,
                         input logic eif, input logic els);
      vec_t v;
      v.rst = r; v.if_req = ir; v.if_addr = 32'h10; v.ls_req = lr; v.ls_addr = 32'h24;
      v.exp_if_gnt = eif; v.exp_ls_gnt = els;
      vecs.push_back(v);
   endtask

   initial begin
      logic              pend_if, pend_ls, r;
      logic [ADDR_W-1:0] pa_if, pa_ls;

      // Reset, then continuous contention: four LS wins, one forced IF, repeat.
      addVec(1, 1, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < STARVE_MAX; k++) addVec(0, 1, 1, 0, 1);
         addVec(0, 1, 1, 1, 0);
      end
      // IF goes idle after three contended LS wins; the count restarts.
      for (int k = 0; k < 3; k++) addVec(0, 1, 1, 0, 1);
      addVec(0, 0, 1, 0, 1);
      for (int k = 0; k < STARVE_MAX; k++) addVec(0, 1, 1, 0, 1);
      addVec(0, 1, 1, 1, 0);
      addVec(0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].if_req, vecs[i].if_addr,
                       vecs[i].ls_req, vecs[i].ls_addr);
         checkOutput();
         check($sformatf("vec%0d_if_gnt", i), 32'(if_gnt), 32'(vecs[i].exp_if_gnt));
         check($sformatf("vec%0d_ls_gnt", i), 32'(ls_gnt), 32'(vecs[i].exp_ls_gnt));
      end

      // IF-only read of byte address 0x8 returns ROM word 2 one cycle later.
      applyStimulus(0, 1, 32'h8, 0, 32'h0);
      checkOutput();
      check("ifonly_gnt", 32'(if_gnt), 32'h1);
      check("ifonly_addr", rom_addr, 32'h8);
      check("ifonly_stall", 32'(stallreq_if), 32'h0);
      applyStimulus(0, 0, 32'h0, 0, 32'h0);
      checkOutput();
      check("ifonly_rvalid", 32'(if_rvalid), 32'h1);
      check("ifonly_rdata", if_rdata, rom_word(32'h8));

      // LS back-to-back over words 0, 1, 2.
      for (int k = 0; k < 4; k++) begin
         if (k < 3) applyStimulus(0, 0, 32'h0, 1, 32'(4 * k));
         else       applyStimulus(0, 0, 32'h0, 0, 32'h0);
         checkOutput();
         if (k < 3) check($sformatf("lsb2b_gnt%0d", k), 32'(ls_gnt), 32'h1);
         if (k > 0) begin
            check($sformatf("lsb2b_rvalid%0d", k), 32'(ls_rvalid), 32'h1);
            check($sformatf("lsb2b_rdata%0d", k), ls_rdata, rom_word(32'(4 * (k - 1))));
         end
      end

      // Idle: port disabled, response registers keep their last words.
      applyStimulus(0, 0, 32'h0, 0, 32'h0);
      checkOutput();
      check("idle_ce", 32'(rom_ce), 32'h0);
      check("idle_addr", rom_addr, 32'h0);
      check("idle_if_rvalid", 32'(if_rvalid), 32'h0);
      check("idle_ls_rvalid", 32'(ls_rvalid), 32'h0);
      check("idle_if_rdata", if_rdata, rom_word(32'h8));
      check("idle_ls_rdata", ls_rdata, rom_word(32'h8));

      // Reset arriving right after a forced IF grant while contention is pending.
      for (int k = 0; k <= STARVE_MAX; k++) begin
         applyStimulus(0, 1, 32'h40, 1, 32'h44);
         checkOutput();
      end
      check("rstmid_forced_if", 32'(if_gnt), 32'h1);
      applyStimulus(1, 1, 32'h40, 1, 32'h44);
      checkOutput();
      check("rstmid_if_gnt", 32'(if_gnt), 32'h0);
      check("rstmid_ls_gnt", 32'(ls_gnt), 32'h0);
      check("rstmid_addr", rom_addr, 32'h0);
      check("rstmid_stall_if", 32'(stallreq_if), 32'h1);
      check("rstmid_stall_ls", 32'(stallreq_ls), 32'h1);
      applyStimulus(0, 1, 32'h40, 1, 32'h44);
      checkOutput();
      check("rstpost_if_rvalid", 32'(if_rvalid), 32'h0);
      check("rstpost_ls_rvalid", 32'(ls_rvalid), 32'h0);
      check("rstpost_if_rdata", if_rdata, 32'h0);
      check("rstpost_ls_rdata", ls_rdata, 32'h0);
      check("rstpost_ls_gnt", 32'(ls_gnt), 32'h1);
      for (int k = 1; k < STARVE_MAX; k++) begin
         applyStimulus(0, 1, 32'h40, 1, 32'h44);
         checkOutput();
      end
      check("rstpost_still_ls", 32'(ls_gnt), 32'h1);
      applyStimulus(0, 1, 32'h40, 1, 32'h44);
      checkOutput();
      check("rstpost_forced_if", 32'(if_gnt), 32'h1);

      // Random traffic obeying the requester rules: hold req and address until granted.
      pend_if = 1'b0; pend_ls = 1'b0; pa_if = '0; pa_ls = '0;
      for (int c = 0; c < 400; c++) begin
         if (!pend_if) begin
            pend_if = ($urandom_range(0, 3) != 0);
            pa_if   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         end
         if (!pend_ls) begin
            pend_ls = ($urandom_range(0, 3) != 0);
            pa_ls   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         end
         r = ($urandom_range(0, 49) == 0);
         applyStimulus(r, pend_if, pa_if, pend_ls, pa_ls);
         checkOutput();
         if (e_if) pend_if = 1'b0;
         if (e_ls) pend_ls = 1'b0;
      end

      applyStimulus(0, 0, 32'h0, 0, 32'h0);
      checkOutput();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single read port of the instruction ROM between the instruction-fetch requester (IF) and a load requester (LS) that reads constants and tables out of code space. Each cycle it grants the port to at most one requester and drives the ROM chip-enable and address. It captures the ROM's combinational output into a per-requester response register one cycle later, and raises stall requests toward the pipeline controller for the denied side. LS has priority, with a starvation guard that forces an IF grant after a bounded number of consecutive LS wins.

## Interface
- ADDR_W, 32, byte address width of both requesters and the ROM address.
- DATA_W, 32, instruction/data word width.
- STARVE_MAX, 4, consecutive contended LS grants after which IF is forced through (1..15).

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request (level; held until granted).
- if_addr  in  ADDR_W  IF byte address; stable while if_req and not granted.
- if_gnt  out  1  IF owns the ROM port this cycle (combinational).
- if_rdata  out  DATA_W  registered IF read word.
- if_rvalid  out  1  if_rdata valid this cycle (one-cycle pulse per grant).
- ls_req, ls_addr, ls_gnt, ls_rdata, ls_rvalid: same meanings for the LS requester.
- stallreq_if  out  1  if_req & ~if_gnt.
- stallreq_ls  out  1  ls_req & ~ls_gnt.
- rom_ce  out  1  ROM chip enable; high only when a grant is issued.
- rom_addr  out  ADDR_W  address of the granted requester, 0 when rom_ce low.
- rom_inst  in  DATA_W  ROM combinational read data (ROM returns 0 when disabled).

## Operation
- Grant, combinational, in cycle t:
  - While rst is high, no grant.
  - Only one req: that side is granted.
  - Both req and starve_cnt == STARVE_MAX: IF is granted.
  - Both req otherwise: LS is granted.
  - No req: no grant, rom_ce = 0.
- rom_ce = if_gnt | ls_gnt. rom_addr is a mux of the granted address and passes byte addresses unchanged; the ROM performs the word indexing.
- Response capture at the rising edge ending cycle t:
  - Granted side: rdata <= rom_inst, rvalid <= 1.
  - Non-granted side: rvalid <= 0, rdata holds its previous value.
- starve_cnt, 4 bits, updated at the edge ending cycle t:
  - Both req and LS granted: increment, saturating at STARVE_MAX.
  - IF granted, or if_req low: clear to 0.
  - Otherwise: hold.
- Requester rules:
  - Request is a level; deassert or change the address only in the cycle after gnt.
  - Asserting req with gnt in the same cycle is a completed transfer.
  - Back-to-back requests from one side are granted every cycle when uncontested.
- Both gnts high in the same cycle is illegal and must never occur (assertion in the bench).

## Timing
- Reset values, all registered after a cycle with rst high: if_rdata = 0, ls_rdata = 0, if_rvalid = 0, ls_rvalid = 0, starve_cnt = 0.
- During rst: if_gnt = ls_gnt = 0, rom_ce = 0, rom_addr = 0. stallreq_* follows its requester's req.
- Latency: a grant in cycle t gives rvalid and rdata in cycle t+1. Throughput is one word per cycle total.
- Reset mid-operation: a grant issued in the cycle before rst produces no rvalid if rst is high at the capture edge, because reset dominates. The counter clears.
- Under continuous contention, IF is granted exactly once every STARVE_MAX+1 cycles, and LS is stalled on that cycle.
- IF dropping its request mid-contention clears the counter, so no forced grant is carried over.
- Simultaneous grant and new request on the other side: the new request is evaluated in the next cycle by the same rules.

## Test plan
- IF-only read: if_req=1, if_addr=0x8, ls_req=0 -> if_gnt=1, rom_ce=1, rom_addr=0x8 in cycle t; if_rvalid=1 and if_rdata=mem word 2 in t+1; stallreq_if=0.
- LS-only back-to-back: ls_addr 0x0, 0x4, 0x8 over three cycles -> ls_gnt high each cycle, ls_rvalid high for three consecutive cycles carrying words 0, 1, 2.
- Contention with STARVE_MAX=4: both req held -> LS granted in cycles 0-3, IF in cycle 4, LS in 5-8, IF in 9. stallreq_if is high in 0-3, stallreq_ls is high in 4.
- Starvation reset by IF idle: both req for 3 cycles, if_req low for 1 cycle, then both req -> 4 further LS grants before IF is forced; the counter never reaches 4 early.
- Idle: no req -> rom_ce=0, rom_addr=0, both rvalid=0, rdata values unchanged.
- Reset mid-operation: rst=1 in the cycle after an IF grant, with contention pending -> no rvalid, both rdata=0, gnts=0 during rst. First cycle after rst with both req -> LS granted, counter starting at 0.
